ff_alloc_walker: RTL

- First-fit allocator engine that sits directly upstream of the header load/store unit (LSU).
- Takes malloc requests from the core and walks a singly linked free list in memory, using only LSU LOAD, INSERT and DELETE operations.
- Splits or unlinks the chosen block and returns the payload pointer.
- The free-list head is a dummy block at FREE_LIST_HEAD_ADDR; its next_addr field points to the first free block.

---
 rtl/ff_alloc_walker_pkg.sv | 75 +++++++
 rtl/ff_alloc_size_calc.sv | 24 ++
 rtl/ff_alloc_walker.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ff_alloc_walker_pkg.sv
// Shared allocator types: header LSU payloads, op codes and walker states.
package ff_alloc_walker_pkg;

  localparam int unsigned DATA_W                 = 64;
  localparam int unsigned HEADER_B               = 2 * DATA_W / 8;
  localparam int unsigned BLOCK_NEXT_ADDR_OFFSET = DATA_W / 8;
  localparam logic [DATA_W-1:0] NULL_ADDR        = '0;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2
  } lsu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_data_t;

  typedef struct packed {
    logic         val;
    lsu_op_e      lsu_op;
    header_data_t header_data;
  } header_data_req_t;

  typedef struct packed {
    logic              val;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_data_rsp_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HEAD_REQ,
    ST_HEAD_RSP,
    ST_CHECK,
    ST_CURR_REQ,
    ST_CURR_RSP,
    ST_SPLIT_REQ,
    ST_SPLIT_RSP,
    ST_HDR_REQ,
    ST_HDR_RSP,
    ST_LINK_REQ,
    ST_LINK_RSP,
    ST_RESP
  } walker_state_e;

  // Builds a valid LSU request.
  function automatic header_data_req_t lsu_cmd(input lsu_op_e op,
                                               input logic [DATA_W-1:0] addr,
                                               input logic [DATA_W-1:0] size,
                                               input logic [DATA_W-1:0] next_addr);
    header_data_req_t r;
    r.val                   = 1'b1;
    r.lsu_op                = op;
    r.header_data.addr      = addr;
    r.header_data.size      = size;
    r.header_data.next_addr = next_addr;
    return r;
  endfunction

  // Response-wait state that follows each request state.
  function automatic walker_state_e rsp_state(input walker_state_e s);
    case (s)
      ST_HEAD_REQ:  return ST_HEAD_RSP;
      ST_CURR_REQ:  return ST_CURR_RSP;
      ST_SPLIT_REQ: return ST_SPLIT_RSP;
      ST_HDR_REQ:   return ST_HDR_RSP;
      ST_LINK_REQ:  return ST_LINK_RSP;
      default:      return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ff_alloc_size_calc.sv
// Block size needed for a request: payload rounded up to ALIGN_B plus header.
module ff_alloc_size_calc
  import ff_alloc_walker_pkg::*;
#(
  parameter int unsigned ALIGN_B  = 8,
  parameter int unsigned HEADER_B = 16
) (
  input  logic [DATA_W-1:0] size,
  output logic [DATA_W-1:0] need_c,
  output logic              ovf_c
);

  localparam int unsigned EXT_W = DATA_W + 1;

  logic [EXT_W-1:0] rounded;
  logic [EXT_W-1:0] total;

  // One extra bit catches a carry from either the roundup or the header add.
  assign rounded = (EXT_W'(size) + EXT_W'(ALIGN_B - 1)) & ~EXT_W'(ALIGN_B - 1);
  assign total   = rounded + EXT_W'(HEADER_B);
  assign need_c  = total[DATA_W-1:0];
  assign ovf_c   = total[DATA_W];

endmodule

// File: rtl/ff_alloc_walker.sv
// First-fit free-list walker driving the header LSU with LOAD/INSERT/DELETE.
// Optional ALLOC_WALKER_STATS_EN adds saturating ok/fail/step counters.
module ff_alloc_walker
  import ff_alloc_walker_pkg::*;
#(
  parameter logic [DATA_W-1:0] FREE_LIST_HEAD_ADDR = 64'h0000_0100,
  parameter int unsigned       ALIGN_B             = 8,
  parameter int unsigned       MIN_SPLIT_B         = 32,
  parameter int unsigned       MAX_WALK            = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_req_val_i,
  output logic              alloc_req_rdy_o,
  input  logic [DATA_W-1:0] alloc_req_size_i,
  output logic              alloc_rsp_val_o,
  input  logic              alloc_rsp_rdy_i,
  output logic [DATA_W-1:0] alloc_rsp_addr_o,
  output logic              alloc_rsp_ok_o,
  output header_data_req_t  lsu_req_o,
  input  logic              lsu_ready_i,
  input  header_data_rsp_t  lsu_rsp_i,
  output logic              lsu_rsp_rdy_o
`ifdef ALLOC_WALKER_STATS_EN
  ,
  output logic [31:0]       stat_ok_o,
  output logic [31:0]       stat_fail_o,
  output logic [31:0]       stat_steps_o
`endif
);

  localparam int unsigned WALK_W = $clog2(MAX_WALK + 1);

  walker_state_e     state;
  logic [DATA_W-1:0] need;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] curr;
  logic [WALK_W-1:0] walk_cnt;
  logic [DATA_W-1:0] calc_need;
  logic              calc_ovf;
  logic              rsp_fire;
  logic              fit;
  logic              split;

  ff_alloc_size_calc #(
    .ALIGN_B (ALIGN_B),
    .HEADER_B(HEADER_B)
  ) u_size_calc (
    .size  (alloc_req_size_i),
    .need_c(calc_need),
    .ovf_c (calc_ovf)
  );

  assign rsp_fire = lsu_rsp_i.val && lsu_rsp_rdy_o;
  assign fit      = lsu_rsp_i.size >= need;
  assign split    = {1'b0, lsu_rsp_i.size} >= ({1'b0, need} + (DATA_W + 1)'(MIN_SPLIT_B));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      alloc_req_rdy_o  <= 1'b1;
      alloc_rsp_val_o  <= 1'b0;
      alloc_rsp_addr_o <= '0;
      alloc_rsp_ok_o   <= 1'b0;
      lsu_req_o        <= '0;
      lsu_rsp_rdy_o    <= 1'b0;
      need             <= '0;
      prev             <= '0;
      curr             <= '0;
      walk_cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (alloc_req_val_i && alloc_req_rdy_o) begin
            alloc_req_rdy_o <= 1'b0;
            need            <= calc_need;
            if (alloc_req_size_i == '0 || calc_ovf) begin
              state            <= ST_RESP;
              alloc_rsp_val_o  <= 1'b1;
              alloc_rsp_addr_o <= NULL_ADDR;
              alloc_rsp_ok_o   <= 1'b0;
            end else begin
              state     <= ST_HEAD_REQ;
              lsu_req_o <= lsu_cmd(OP_LOAD, FREE_LIST_HEAD_ADDR, '0, '0);
            end
          end
        end

        // Hold the request until the LSU takes it, then wait for its response.
        ST_HEAD_REQ, ST_CURR_REQ, ST_SPLIT_REQ, ST_HDR_REQ, ST_LINK_REQ: begin
          if (lsu_ready_i) begin
            lsu_req_o.val <= 1'b0;
            lsu_rsp_rdy_o <= 1'b1;
            state         <= rsp_state(state);
          end
        end

        ST_HEAD_RSP: begin
          if (rsp_fire) begin
            lsu_rsp_rdy_o <= 1'b0;
            prev          <= FREE_LIST_HEAD_ADDR;
            curr          <= lsu_rsp_i.next_addr;
            walk_cnt      <= '0;
            state         <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (curr == NULL_ADDR || walk_cnt == WALK_W'(MAX_WALK)) begin
            state            <= ST_RESP;
            alloc_rsp_val_o  <= 1'b1;
            alloc_rsp_addr_o <= NULL_ADDR;
            alloc_rsp_ok_o   <= 1'b0;
          end else begin
            state     <= ST_CURR_REQ;
            lsu_req_o <= lsu_cmd(OP_LOAD, curr, '0, '0);
          end
        end

        ST_CURR_RSP: begin
          if (rsp_fire) begin
            lsu_rsp_rdy_o <= 1'b0;
            if (split) begin
              state     <= ST_SPLIT_REQ;
              lsu_req_o <= lsu_cmd(OP_INSERT, curr + need, lsu_rsp_i.size - need,
                                   lsu_rsp_i.next_addr);
            end else if (fit) begin
              state     <= ST_LINK_REQ;
              lsu_req_o <= lsu_cmd(OP_DELETE, prev, '0, lsu_rsp_i.next_addr);
            end else begin
              prev     <= curr;
              curr     <= lsu_rsp_i.next_addr;
              walk_cnt <= walk_cnt + WALK_W'(1);
              state    <= ST_CHECK;
            end
          end
        end

        // Remainder goes in first so prev never points at an unwritten header.
        ST_SPLIT_RSP: begin
          if (rsp_fire) begin
            lsu_rsp_rdy_o <= 1'b0;
            state         <= ST_HDR_REQ;
            lsu_req_o     <= lsu_cmd(OP_INSERT, curr, need, NULL_ADDR);
          end
        end

        ST_HDR_RSP: begin
          if (rsp_fire) begin
            lsu_rsp_rdy_o <= 1'b0;
            state         <= ST_LINK_REQ;
            lsu_req_o     <= lsu_cmd(OP_DELETE, prev, '0, curr + need);
          end
        end

        ST_LINK_RSP: begin
          if (rsp_fire) begin
            lsu_rsp_rdy_o    <= 1'b0;
            state            <= ST_RESP;
            alloc_rsp_val_o  <= 1'b1;
            alloc_rsp_addr_o <= curr + DATA_W'(HEADER_B);
            alloc_rsp_ok_o   <= 1'b1;
          end
        end

        ST_RESP: begin
          if (alloc_rsp_rdy_i) begin
            alloc_rsp_val_o  <= 1'b0;
            alloc_rsp_addr_o <= '0;
            alloc_rsp_ok_o   <= 1'b0;
            alloc_req_rdy_o  <= 1'b1;
            state            <= ST_IDLE;
          end
        end

        default: begin
          state           <= ST_IDLE;
          alloc_req_rdy_o <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALLOC_WALKER_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_ok_o    <= '0;
      stat_fail_o  <= '0;
      stat_steps_o <= '0;
    end else begin
      if (state == ST_RESP && alloc_rsp_rdy_i) begin
        if (alloc_rsp_ok_o && stat_ok_o != '1)
          stat_ok_o <= stat_ok_o + 32'd1;
        if (!alloc_rsp_ok_o && stat_fail_o != '1)
          stat_fail_o <= stat_fail_o + 32'd1;
      end
      if (state == ST_CURR_RSP && rsp_fire && stat_steps_o != '1)
        stat_steps_o <= stat_steps_o + 32'd1;
    end
  end
`endif

endmodule
